// File: rtl/wgt_skew_feeder.sv
// Purpose : weight SRAM read issue plus diagonal skew feeder for the systolic array.
// Latency : addr_valid beat -> wgt_valid[c] after 3+c cycles; done pulses NUM_COL+3 cycles after the last beat.
// Backpressure: none; beats are accepted in IDLE/ISSUE only, beats seen in DRAIN/DONE are dropped.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   addr_valid/wgt_addr row address beats from the weight address controller
//   mem_rd_en/_addr     registered SRAM read request, one cycle after the accepted beat
//   mem_rd_data         SRAM row, valid the cycle after mem_rd_en
//   wgt_out/wgt_valid   skewed weights, column c delayed c cycles after column 0
//   busy, done          job in progress / one-cycle completion pulse
// Optional feature: define WGT_ZERO_PAD_EN to force wgt_out columns to zero while not valid;
// by default a column holds its last valid weight.

module wgt_skew_feeder #(
   parameter int KERNEL_SIZE = 3,
   parameter int NO_CHANNEL  = 3,
   parameter int ADDR_WIDTH  = 9,
   parameter int DATA_WIDTH  = 8,
   parameter int NUM_COL     = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           addr_valid,
   input  logic [ADDR_WIDTH-1:0]          wgt_addr,
   output logic                           mem_rd_en,
   output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
   input  logic [NUM_COL*DATA_WIDTH-1:0]  mem_rd_data,
   output logic [NUM_COL*DATA_WIDTH-1:0]  wgt_out,
   output logic [NUM_COL-1:0]             wgt_valid,
   output logic                           busy,
   output logic                           done
);

   localparam int ROWS      = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
   localparam int RCW       = $clog2(ROWS + 1);
   localparam int DRAIN_CYC = NUM_COL + 2;
   localparam int DCW       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   localparam logic [RCW-1:0] ROWS_C      = RCW'(ROWS);
   localparam logic [DCW-1:0] DRAIN_LAST  = DCW'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_d, state_q;
   logic [RCW-1:0]        row_cnt_d, row_cnt_q;
   logic [DCW-1:0]        drain_cnt_d, drain_cnt_q;
   logic                  mem_rd_en_d, mem_rd_en_q;
   logic [ADDR_WIDTH-1:0] mem_rd_addr_d, mem_rd_addr_q;
   logic                  busy_d, busy_q;
   logic                  done_d, done_q;
   logic                  rd_vld_q;
   logic                  accept;

   // ---------------------------------------------------------------
   // Control FSM and read issue
   // ---------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      row_cnt_d     = row_cnt_q;
      drain_cnt_d   = drain_cnt_q;
      done_d        = 1'b0;
      accept        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (addr_valid) begin
               accept      = 1'b1;
               row_cnt_d   = RCW'(1);
               drain_cnt_d = '0;
               state_d     = (ROWS == 1) ? S_DRAIN : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (addr_valid) begin
               accept    = 1'b1;
               row_cnt_d = row_cnt_q + 1'b1;
               if (row_cnt_q + 1'b1 == ROWS_C) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         S_DRAIN: begin
            // Drain covers the SRAM and capture latency plus the deepest skew chain.
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               drain_cnt_d = '0;
               row_cnt_d   = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d        = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      mem_rd_en_d   = accept;
      mem_rd_addr_d = accept ? wgt_addr : mem_rd_addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         row_cnt_q     <= '0;
         drain_cnt_q   <= '0;
         mem_rd_en_q   <= 1'b0;
         mem_rd_addr_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rd_vld_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_rd_addr_q <= mem_rd_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         // SRAM returns data one cycle after the read strobe.
         rd_vld_q      <= mem_rd_en_q;
      end
   end

   assign mem_rd_en   = mem_rd_en_q;
   assign mem_rd_addr = mem_rd_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;

   // ---------------------------------------------------------------
   // Per-column skew chains: stage 0 captures the SRAM row, column c
   // then passes through c more stages. Data stages load only when
   // their incoming valid is set, so bubbles never overwrite a held weight.
   // ---------------------------------------------------------------
   for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      localparam int DEPTH = c + 1;

      logic [DEPTH-1:0]      vld_d, vld_q;
      logic [DATA_WIDTH-1:0] dat_d [DEPTH];
      logic [DATA_WIDTH-1:0] dat_q [DEPTH];

      always_comb begin
         vld_d[0] = rd_vld_q;
         dat_d[0] = rd_vld_q ? mem_rd_data[c*DATA_WIDTH +: DATA_WIDTH] : dat_q[0];
         for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
               dat_q[k] <= '0;
            end
         end else begin
            vld_q <= vld_d;
            for (int k = 0; k < DEPTH; k++) begin
               dat_q[k] <= dat_d[k];
            end
         end
      end

      assign wgt_valid[c] = vld_q[DEPTH-1];

`ifdef WGT_ZERO_PAD_EN
      assign wgt_out[c*DATA_WIDTH +: DATA_WIDTH] = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
`else
      assign wgt_out[c*DATA_WIDTH +: DATA_WIDTH] = dat_q[DEPTH-1];
`endif
   end

endmodule

// File: tb/tb_wgt_skew_feeder.sv
// Purpose : directed self-checking bench for wgt_skew_feeder (default parameters).
// Latency : outputs recorded at the falling edge of every cycle, then compared per scenario.
// Backpressure: none; the bench drives addr_valid beats and a one-cycle SRAM model.

module tb_wgt_skew_feeder;

   localparam int AW   = 9;
   localparam int DW   = 8;
   localparam int NCOL = 16;
   localparam int N    = 128;

`ifdef WGT_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 addr_valid;
   logic [AW-1:0]        wgt_addr;
   logic                 mem_rd_en;
   logic [AW-1:0]        mem_rd_addr;
   logic [NCOL*DW-1:0]   mem_rd_data = '0;
   logic [NCOL*DW-1:0]   wgt_out;
   logic [NCOL-1:0]      wgt_valid;
   logic                 busy;
   logic                 done;

   int compared   = 0;
   int mismatched = 0;

   // stimulus and hand-set expectations, indexed by cycle within a scenario
   bit            s_av   [N];
   bit            s_acc  [N];
   bit            s_rst  [N];
   logic [AW-1:0] s_addr [N];
   bit            e_done [N];
   bit            e_busy [N];

   // recorded DUT outputs
   logic               r_en   [N];
   logic [AW-1:0]      r_addr [N];
   logic [NCOL-1:0]    r_vld  [N];
   logic [NCOL*DW-1:0] r_out  [N];
   logic               r_done [N];
   logic               r_busy [N];

   wgt_skew_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .addr_valid  (addr_valid),
      .wgt_addr    (wgt_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .wgt_out     (wgt_out),
      .wgt_valid   (wgt_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // SRAM model: row at address 16*k holds byte k in every column
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= {NCOL{8'(mem_rd_addr >> 4)}};
   end

   task automatic check(input string tag, input int t, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic clear_stim();
      for (int t = 0; t < N; t++) begin
         s_av[t] = 0; s_acc[t] = 0; s_rst[t] = 0; s_addr[t] = '0;
         e_done[t] = 0; e_busy[t] = 0;
      end
   endtask

   task automatic add_beat(input int t, input int k);
      s_av[t] = 1; s_acc[t] = 1; s_addr[t] = AW'(16 * k);
   endtask

   task automatic add_job(input int t0);
      for (int k = 0; k < 27; k++) add_beat(t0 + k, k);
   endtask

   task automatic set_busy(input int a, input int b);
      for (int t = a; t <= b; t++) e_busy[t] = 1;
   endtask

   task automatic do_reset();
      rst = 1'b1; addr_valid = 1'b1; wgt_addr = 9'h1F0;
      @(posedge clk); #1;
      rst = 1'b0; addr_valid = 1'b0;
      check("rst_rd_en",   -1, 128'(mem_rd_en),   '0);
      check("rst_rd_addr", -1, 128'(mem_rd_addr), '0);
      check("rst_wgt_out", -1, 128'(wgt_out),     '0);
      check("rst_wgt_vld", -1, 128'(wgt_valid),   '0);
      check("rst_busy",    -1, 128'(busy),        '0);
      check("rst_done",    -1, 128'(done),        '0);
   endtask

   task automatic run(input int n);
      for (int t = 0; t < n; t++) begin
         rst        = s_rst[t];
         addr_valid = s_av[t];
         wgt_addr   = s_av[t] ? s_addr[t] : AW'($urandom);
         @(negedge clk);
         r_en[t] = mem_rd_en; r_addr[t] = mem_rd_addr; r_vld[t] = wgt_valid;
         r_out[t] = wgt_out; r_done[t] = done; r_busy[t] = busy;
         @(posedge clk); #1;
      end
      rst = 1'b0; addr_valid = 1'b0;
   endtask

   function automatic bit rst_in(input int a, input int b);
      for (int i = a; i <= b; i++) if (i >= 0 && i < N && s_rst[i]) return 1;
      return 0;
   endfunction

   // expected outputs: beat at s -> read at s+1, column c valid at s+3+c
   task automatic verify(input string nm, input int n);
      logic [DW-1:0]      hold [NCOL];
      logic [NCOL-1:0]    ev;
      logic [NCOL*DW-1:0] eo;
      bit                 een;
      for (int c = 0; c < NCOL; c++) hold[c] = '0;
      for (int u = 0; u < n; u++) begin
         een = (u >= 1) && s_acc[u-1] && !s_rst[u-1];
         check({nm, "_rd_en"}, u, 128'(r_en[u]), 128'(een));
         if (een) check({nm, "_rd_addr"}, u, 128'(r_addr[u]), 128'(s_addr[u-1]));
         if (u >= 1 && s_rst[u-1]) for (int c = 0; c < NCOL; c++) hold[c] = '0;
         for (int c = 0; c < NCOL; c++) begin
            int s;
            s = u - 3 - c;
            ev[c] = (s >= 0) && s_acc[s] && !rst_in(s, u - 1);
            if (ev[c]) hold[c] = 8'(s_addr[s] >> 4);
            eo[c*DW +: DW] = (ev[c] || !PAD) ? hold[c] : 8'h00;
         end
         check({nm, "_wgt_valid"}, u, 128'(r_vld[u]), 128'(ev));
         check({nm, "_wgt_out"},   u, 128'(r_out[u]), 128'(eo));
         check({nm, "_done"},      u, 128'(r_done[u]), 128'(e_done[u]));
         check({nm, "_busy"},      u, 128'(r_busy[u]), 128'(e_busy[u]));
      end
   endtask

   initial begin
      rst = 1'b1; addr_valid = 1'b0; wgt_addr = '0;
      @(posedge clk); #1;

      // 1: 27 back-to-back beats
      clear_stim();
      add_job(0); e_done[45] = 1; set_busy(1, 44);
      do_reset(); run(56); verify("job", 56);
      check("hand_en_t1",    1,  128'(r_en[1]),        128'(1));
      check("hand_en_t27",   27, 128'(r_en[27]),       128'(1));
      check("hand_en_t28",   28, 128'(r_en[28]),       128'(0));
      check("hand_v0_t2",    2,  128'(r_vld[2][0]),    128'(0));
      check("hand_v0_t3",    3,  128'(r_vld[3][0]),    128'(1));
      check("hand_c0_t29",   29, 128'(r_out[29][7:0]), 128'(8'd26));
      check("hand_v0_t30",   30, 128'(r_vld[30][0]),   128'(0));
      check("hand_v15_t17",  17, 128'(r_vld[17][15]),  128'(0));
      check("hand_v15_t18",  18, 128'(r_vld[18][15]),  128'(1));
      check("hand_v15_t44",  44, 128'(r_vld[44][15]),  128'(1));
      check("hand_v15_t45",  45, 128'(r_vld[45][15]),  128'(0));
      check("hand_c15_t10",  10, 128'(r_out[10][127:120]), 128'(8'd0));
      check("hand_c15_t50",  50, 128'(r_out[50][127:120]), PAD ? 128'(0) : 128'(8'd26));
      check("hand_done_t45", 45, 128'(r_done[45]),     128'(1));
      check("hand_busy_t46", 46, 128'(r_busy[46]),     128'(0));

      // 2: one-cycle gap after beat 10
      clear_stim();
      for (int k = 0; k <= 10; k++) add_beat(k, k);
      for (int k = 11; k < 27; k++) add_beat(k + 1, k);
      e_done[46] = 1; set_busy(1, 45);
      do_reset(); run(56); verify("gap", 56);
      check("hand_gap_v5_t19", 19, 128'(r_vld[19][5]), 128'(0));
      check("hand_gap_done",   46, 128'(r_done[46]),   128'(1));

      // 3: stray beats during DRAIN and DONE are ignored
      clear_stim();
      add_job(0);
      s_av[30] = 1; s_addr[30] = 9'h1F0;
      s_av[35] = 1; s_addr[35] = 9'h1E0;
      s_av[44] = 1; s_addr[44] = 9'h1D0;
      s_av[45] = 1; s_addr[45] = 9'h1C0;
      e_done[45] = 1; set_busy(1, 44);
      do_reset(); run(56); verify("drain", 56);

      // 4: reset mid-job, then a fresh job at t=25
      clear_stim();
      for (int k = 0; k < 20; k++) add_beat(k, k);
      s_rst[20] = 1;
      add_job(25);
      set_busy(1, 20); set_busy(26, 69); e_done[70] = 1;
      do_reset(); run(80); verify("abort", 80);
      check("hand_abort_vld", 21, 128'(r_vld[21]), 128'(0));
      check("hand_abort_out", 21, 128'(r_out[21]), 128'(0));

      // 5: second job starts the cycle after done
      clear_stim();
      add_job(0); add_job(46);
      e_done[45] = 1; e_done[91] = 1;
      set_busy(1, 44); set_busy(47, 90);
      do_reset(); run(100); verify("b2b", 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
